result_drain: RTL and testbench

RESULT_DRAIN -- requirements
Module: resultDrain

---
 rtl/result_drain.sv | 148 ++++++++++++++
 tb/tb_result_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: captures a square matrix of signed PE accumulators on request,
// clears the array, then streams the captured matrix out one row per
// valid/ready handshake. Each element is arithmetically right-shifted and
// saturated to the output width. Rows leave in order 0..matrixSize-1 and a
// one-cycle done pulse follows the last handshake.
module result_drain #(
  parameter int matrixSize  = 8,
  parameter int accSize     = 32,
  parameter int outSize     = 16,
  parameter int shiftAmount = 4,
  localparam int IDX_W      = (matrixSize > 1) ? $clog2(matrixSize) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [accSize-1:0] accInputs [matrixSize][matrixSize],
  output logic                      clearArray,
  output logic                      busy,
  output logic                      rowValid,
  input  logic                      rowReady,
  output logic signed [outSize-1:0] rowData [matrixSize],
  output logic [IDX_W-1:0]          rowIndex,
  output logic                      rowLast,
  output logic                      done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(matrixSize - 1);

  // Saturation bounds expressed at accumulator width so the clamp compares
  // the full shifted value before any bits are dropped.
  localparam logic signed [accSize-1:0] SAT_HI =
    accSize'((64'sd1 <<< (outSize - 1)) - 64'sd1);
  localparam logic signed [accSize-1:0] SAT_LO =
    accSize'(-(64'sd1 <<< (outSize - 1)));

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                clear_q, clear_d;
  logic                done_q, done_d;
  logic                capture;
  logic signed [accSize-1:0] cap_q [matrixSize][matrixSize];

  // Floor-shift (>>> rounds toward negative infinity) then clamp to the
  // signed output range.
  function automatic logic signed [outSize-1:0] requant(
    input logic signed [accSize-1:0] acc
  );
    logic signed [accSize-1:0] sh;
    sh = acc >>> shiftAmount;
    if (sh > SAT_HI) begin
      sh = SAT_HI;
    end else if (sh < SAT_LO) begin
      sh = SAT_LO;
    end
    return sh[outSize-1:0];
  endfunction

  // Next-state logic: IDLE waits for start, SEND advances one row per handshake.
  // start is only looked at in IDLE, so a start during SEND (including one on
  // the final handshake edge) never triggers a second capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clear_d = 1'b0;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          clear_d = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (rowReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers; reset wins over start and over a pending handshake,
  // so a mid-transfer reset drops the transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clear_q <= clear_d;
      done_q  <= done_d;
    end
  end

  // Capture buffer: loaded once per transfer so later accInputs activity
  // (the array restarting after clearArray) cannot leak into streamed rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < matrixSize; r++) begin
        for (int c = 0; c < matrixSize; c++) begin
          cap_q[r][c] <= '0;
        end
      end
    end else if (capture) begin
      for (int r = 0; r < matrixSize; r++) begin
        for (int c = 0; c < matrixSize; c++) begin
          cap_q[r][c] <= accInputs[r][c];
        end
      end
    end
  end

  assign busy       = (state_q == S_SEND);
  assign rowValid   = busy;
  assign rowIndex   = idx_q;
  assign rowLast    = rowValid && (idx_q == LAST_IDX);
  assign clearArray = clear_q;
  assign done       = done_q;

  // Requantize the selected captured row; the bus is forced to zero when idle.
  always_comb begin
    for (int j = 0; j < matrixSize; j++) begin
      rowData[j] = '0;
      if (rowValid) begin
        rowData[j] = requant(cap_q[idx_q][j]);
      end
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: scoreboard of expected rows filled at capture time,
// drained and compared as the DUT presents rows.
module tb_result_drain;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic reset, start, rowReady;
  logic signed [AW-1:0] acc [N][N];
  logic clearArray, busy, rowValid, rowLast, done;
  logic signed [OW-1:0] rowData [N];
  logic [2:0] rowIndex;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [OW*N-1:0] row;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  result_drain #(.matrixSize(N), .accSize(AW), .outSize(OW), .shiftAmount(SH)) dut (
    .clk(clk), .reset(reset), .start(start), .accInputs(acc),
    .clearArray(clearArray), .busy(busy), .rowValid(rowValid),
    .rowReady(rowReady), .rowData(rowData), .rowIndex(rowIndex),
    .rowLast(rowLast), .done(done)
  );

  // Reference requantization: floor division by 2^SH via remainder, then clamp.
  function automatic logic [OW-1:0] model(input logic signed [AW-1:0] a);
    longint v, p, r;
    v = longint'(a);
    p = longint'(1) << SH;
    r = v % p;
    if (r < 0) r = r + p;
    v = (v - r) / p;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[OW-1:0];
  endfunction

  task automatic push_rows();
    exp_t e;
    for (int r = 0; r < N; r++) begin
      e.idx = r;
      for (int c = 0; c < N; c++) e.row[c*OW +: OW] = model(acc[r][c]);
      sb.push_back(e);
    end
  endtask

  function automatic logic [OW*N-1:0] got_row();
    logic [OW*N-1:0] g;
    for (int c = 0; c < N; c++) g[c*OW +: OW] = rowData[c];
    return g;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        acc[r][c] = ((r + c) % 2 == 0) ? AW'($urandom) :
                    AW'(int'($urandom_range(0, 2000000)) - 1000000);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rowReady = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (rowValid !== 1'b0) begin fails++; $display("FAIL reset_rowValid got %b want 0", rowValid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (clearArray !== 1'b0) begin fails++; $display("FAIL reset_clear got %b want 0", clearArray); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (rowIndex !== 3'd0) begin fails++; $display("FAIL reset_rowIndex got %0d want 0", rowIndex); end
    tests++; if (got_row() !== '0) begin fails++; $display("FAIL reset_rowData got %h want 0", got_row()); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_capture();
    int hs, cyc, clr;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) acc[r][c] = 256;
    start = 1'b1; rowReady = 1'b1; push_rows();
    @(negedge clk); start = 1'b0;
    tests++; if (clearArray !== 1'b1) begin fails++; $display("FAIL cap_clear got %b want 1", clearArray); end
    tests++; if (rowValid !== 1'b1) begin fails++; $display("FAIL cap_latency rowValid got %b want 1", rowValid); end
    hs = 0; cyc = 0; clr = 0;
    while (hs < N && cyc < 50) begin
      if (cyc > 0) clr += int'(clearArray);
      tests++;
      if (rowValid !== 1'b1 || sb.size() == 0) begin
        fails++; $display("FAIL cap_stream rowValid got %b want 1 (queued %0d)", rowValid, sb.size());
      end else begin
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL cap_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        tests++; if (rowLast !== (sb[0].idx == N-1)) begin fails++; $display("FAIL cap_rowLast got %b want %b", rowLast, sb[0].idx == N-1); end
        tests++; if (rowData[5] !== 16'sd16) begin fails++; $display("FAIL cap_value got %0d want 16", rowData[5]); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL cap_early_done got %b want 0", done); end
        void'(sb.pop_front()); hs++;
      end
      @(negedge clk); cyc++;
    end
    tests++; if (hs != N) begin fails++; $display("FAIL cap_timeout handshakes got %0d want %0d", hs, N); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL cap_done got %b want 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cap_busy_after got %b want 0", busy); end
    tests++; if (rowValid !== 1'b0) begin fails++; $display("FAIL cap_valid_after got %b want 0", rowValid); end
    tests++; if (clr != 0) begin fails++; $display("FAIL cap_extra_clear got %0d want 0", clr); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL cap_done_width got %b want 0", done); end
    rowReady = 1'b0;
  endtask

  task automatic test_saturation();
    int hs, cyc;
    fill_random();
    acc[2][0] = -32'sd1;
    acc[2][1] = 32'sd17;
    acc[2][2] = 32'sh0010_0000;
    acc[2][3] = 32'sh8000_0000;
    start = 1'b1; rowReady = 1'b1; push_rows();
    @(negedge clk); start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < N && cyc < 50) begin
      if (rowValid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL sat_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        if (rowIndex == 3'd2) begin
          tests++; if (rowData[0] !== -16'sd1) begin fails++; $display("FAIL sat_neg1 got %0d want -1", rowData[0]); end
          tests++; if (rowData[1] !== 16'sd1) begin fails++; $display("FAIL sat_17 got %0d want 1", rowData[1]); end
          tests++; if (rowData[2] !== 16'sd32767) begin fails++; $display("FAIL sat_pos got %0d want 32767", rowData[2]); end
          tests++; if (rowData[3] !== -16'sd32768) begin fails++; $display("FAIL sat_negmax got %0d want -32768", rowData[3]); end
        end
        void'(sb.pop_front()); hs++;
      end
      @(negedge clk); cyc++;
    end
    tests++; if (hs != N) begin fails++; $display("FAIL sat_timeout handshakes got %0d want %0d", hs, N); end
    rowReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs, cyc, dn;
    logic stalled;
    logic [OW*N-1:0] held_row;
    logic [2:0] held_idx;
    fill_random();
    start = 1'b1; push_rows();
    @(negedge clk); start = 1'b0;
    hs = 0; cyc = 0; dn = 0; stalled = 1'b0; held_row = '0; held_idx = '0;
    while (hs < N && cyc < 300) begin
      dn += int'(done);
      if (stalled) begin
        tests++;
        if (got_row() !== held_row || rowIndex !== held_idx) begin
          fails++; $display("FAIL bp_stable idx got %0d want %0d data got %h want %h", rowIndex, held_idx, got_row(), held_row);
        end
      end
      rowReady = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (rowValid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL bp_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        if (rowReady) begin
          void'(sb.pop_front()); hs++;
        end else begin
          stalled = 1'b1; held_row = got_row(); held_idx = rowIndex;
        end
      end
      @(negedge clk); cyc++;
    end
    rowReady = 1'b0;
    tests++; if (hs != N) begin fails++; $display("FAIL bp_timeout handshakes got %0d want %0d", hs, N); end
    dn += int'(done);
    tests++; if (rowValid !== 1'b0) begin fails++; $display("FAIL bp_extra_row rowValid got %b want 0", rowValid); end
    @(negedge clk);
    dn += int'(done);
    tests++; if (dn != 1) begin fails++; $display("FAIL bp_done_count got %0d want 1", dn); end
  endtask

  task automatic test_isolation();
    int hs, cyc, clr;
    fill_random();
    start = 1'b1; rowReady = 1'b1; push_rows();
    @(negedge clk);
    clr = int'(clearArray);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) acc[r][c] = 32'h7FFF;
    hs = 0; cyc = 0;
    while (hs < N && cyc < 50) begin
      if (cyc > 0) clr += int'(clearArray);
      if (rowValid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL iso_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        void'(sb.pop_front()); hs++;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0; rowReady = 1'b0;
    tests++; if (hs != N) begin fails++; $display("FAIL iso_timeout handshakes got %0d want %0d", hs, N); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL iso_recapture busy got %b want 0", busy); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL iso_done got %b want 1", done); end
    clr += int'(clearArray);
    @(negedge clk);
    clr += int'(clearArray);
    tests++; if (clr != 1) begin fails++; $display("FAIL iso_clear_count got %0d want 1", clr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL iso_idle busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int hs, cyc, dn;
    fill_random();
    start = 1'b1; rowReady = 1'b1; push_rows();
    @(negedge clk); start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 50) begin
      if (rowValid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL rst_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        void'(sb.pop_front()); hs++;
      end
      @(negedge clk); cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rowReady = 1'b0;
    sb.delete();
    tests++; if (rowValid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", rowValid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    tests++; if (rowIndex !== 3'd0) begin fails++; $display("FAIL rst_mid_index got %0d want 0", rowIndex); end
    tests++; if (got_row() !== '0) begin fails++; $display("FAIL rst_mid_data got %h want 0", got_row()); end
    dn = int'(done);
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    tests++; if (dn != 0) begin fails++; $display("FAIL rst_mid_done got %0d pulses want 0", dn); end
    fill_random();
    start = 1'b1; rowReady = 1'b1; push_rows();
    @(negedge clk); start = 1'b0;
    tests++; if (rowIndex !== 3'd0) begin fails++; $display("FAIL rst_restart_index got %0d want 0", rowIndex); end
    hs = 0; cyc = 0;
    while (hs < N && cyc < 50) begin
      if (rowValid === 1'b1 && sb.size() > 0) begin
        tests++;
        if (rowIndex !== 3'(sb[0].idx) || got_row() !== sb[0].row) begin
          fails++; $display("FAIL rst_restart_row idx got %0d want %0d data got %h want %h", rowIndex, sb[0].idx, got_row(), sb[0].row);
        end
        void'(sb.pop_front()); hs++;
      end
      @(negedge clk); cyc++;
    end
    rowReady = 1'b0;
    tests++; if (hs != N) begin fails++; $display("FAIL rst_restart_timeout handshakes got %0d want %0d", hs, N); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL rst_restart_done got %b want 1", done); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rowReady = 1'b0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) acc[r][c] = '0;
    test_reset();
    test_capture();
    test_saturation();
    test_backpressure();
    test_isolation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
